// File: rtl/game_fsm.sv
// -----------------------------------------------------------------------------
// game_fsm -- top-level sequencer for the dino game.
//
// Owns the 2-bit game state that steers the game clock generator and the
// renderers, counts the score in packed BCD on each rising edge of the
// generator's divided clock, ends the run on collision, and emits a one-cycle
// milestone pulse whenever the score reaches a multiple of 100.
//
// Optional feature macro: GAME_FSM_HISCORE_EN
//   defined   -> high_score register + unsigned compare on the START->END edge
//   undefined -> high_score is a constant 16'h0000 (no register, no compare)
//
// Parameters
//   RESET_CYCLES  cycles spent in RESET before re-entering START (1..255)
//
// Ports
//   clk         in   1   system clock
//   rst         in   1   synchronous active-high reset
//   btn_start   in   1   debounced start/restart button (level)
//   collision   in   1   dino/obstacle overlap (level)
//   game_clk    in   1   divided game clock, sampled as data in the clk domain
//   game_state  out  2   0 INIT, 1 START, 2 END, 3 RESET
//   score       out  16  current score, 4-digit packed BCD
//   high_score  out  16  best score since rst, packed BCD
//   milestone   out  1   one-cycle pulse when score hits a multiple of 100
// -----------------------------------------------------------------------------
module game_fsm #(
  parameter int unsigned RESET_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_start,
  input  logic        collision,
  input  logic        game_clk,
  output logic [1:0]  game_state,
  output logic [15:0] score,
  output logic [15:0] high_score,
  output logic        milestone
);

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_START = 2'd1,
    S_END   = 2'd2,
    S_RESET = 2'd3
  } state_e;

  localparam logic [7:0]  RCNT_LOAD = 8'(RESET_CYCLES - 1);
  localparam logic [15:0] SCORE_MAX = 16'h9999;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e      state_q,     state_d;
  logic        btn_prev_q,  btn_prev_d;
  logic        gclk_prev_q, gclk_prev_d;
  logic [15:0] score_q,     score_d;
  logic        ms_q,        ms_d;
  logic [7:0]  rcnt_q,      rcnt_d;

  logic        start_pulse;
  logic        tick;
  logic [15:0] score_inc;

  // Packed-BCD +1 with ripple carry across the four digits. Saturation is
  // handled by the caller, so 9999 never reaches this function in use.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (v[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    start_pulse = btn_start & ~btn_prev_q;
    tick        = game_clk  & ~gclk_prev_q;
    score_inc   = bcd_inc(score_q);

    state_d     = state_q;
    score_d     = score_q;
    ms_d        = 1'b0;
    rcnt_d      = rcnt_q;
    btn_prev_d  = btn_start;
    gclk_prev_d = game_clk;

    case (state_q)
      S_INIT: begin
        if (start_pulse) begin
          state_d = S_START;
          score_d = 16'h0000;
        end
      end

      S_START: begin
        // Collision takes priority over a coincident tick: the run ends on
        // the score shown before the tick.
        if (collision) begin
          state_d = S_END;
        end else if (tick && (score_q != SCORE_MAX)) begin
          score_d = score_inc;
          ms_d    = (score_inc[7:0] == 8'h00);
        end
      end

      S_END: begin
        // Score is left untouched so the final value stays on screen.
        if (start_pulse) begin
          state_d = S_RESET;
          rcnt_d  = RCNT_LOAD;
        end
      end

      S_RESET: begin
        // Dwell is RCNT_LOAD+1 cycles: the entry cycle counts as one.
        if (rcnt_q == 8'd0) begin
          state_d = S_START;
          score_d = 16'h0000;
        end else begin
          rcnt_d = rcnt_q - 8'd1;
        end
      end

      default: begin
        state_d = S_INIT;
      end
    endcase
  end

`ifdef GAME_FSM_HISCORE_EN
  // ---------------------------------------------------------------------------
  // High score: captured on the START->END edge. Packed BCD orders the same
  // way as its unsigned binary reading, so a plain compare is sufficient.
  // ---------------------------------------------------------------------------
  logic [15:0] hs_q, hs_d;

  always_comb begin
    hs_d = hs_q;
    if ((state_q == S_START) && collision && (score_q > hs_q)) begin
      hs_d = score_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hs_q <= 16'h0000;
    end else begin
      hs_q <= hs_d;
    end
  end

  assign high_score = hs_q;
`else
  assign high_score = 16'h0000;
`endif

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_INIT;
      btn_prev_q  <= 1'b0;
      gclk_prev_q <= 1'b0;
      score_q     <= 16'h0000;
      ms_q        <= 1'b0;
      rcnt_q      <= 8'd0;
    end else begin
      state_q     <= state_d;
      btn_prev_q  <= btn_prev_d;
      gclk_prev_q <= gclk_prev_d;
      score_q     <= score_d;
      ms_q        <= ms_d;
      rcnt_q      <= rcnt_d;
    end
  end

  assign game_state = state_q;
  assign score      = score_q;
  assign milestone  = ms_q;

endmodule

// File: doc/game_fsm.md
# game_fsm

Top-level game sequencer for the dino game. It owns the 2-bit `game_state` that drives the speed-ramping game clock generator and the renderers. It counts the score in packed BCD on each rising edge of that generator's `clk_div`, and ends the run on collision. It holds a high score and emits a milestone pulse every 100 points.

## Interface
Parameters:
- `RESET_CYCLES`, default 4: cycles spent in RESET before re-entering START; legal range 1..255.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-high; one clock, `clk`.
- `btn_start`  in  1  debounced start/restart button, level; synchronous to `clk`.
- `collision`  in  1  dino/obstacle overlap, level; synchronous to `clk`.
- `game_clk`  in  1  `clk_div` from the game clock generator; a `clk`-domain register output, sampled as data.
- `game_state`  out  2  0 INIT, 1 START, 2 END, 3 RESET.
- `score`  out  16  current score, 4-digit packed BCD.
- `high_score`  out  16  best score since `rst`, packed BCD.
- `milestone`  out  1  one-cycle pulse when score crosses a multiple of 100.

## Operation
- Edge detection:
  - Registers `btn_prev` and `gclk_prev` hold the previous-cycle samples; both reset to 0.
  - `start_pulse = btn_start & ~btn_prev`.
  - `tick = game_clk & ~gclk_prev`.
- State transitions, registered:
  - INIT: `start_pulse` -> START. Everything else is ignored.
  - START: `collision` -> END. `btn_start` is ignored.
  - END: `start_pulse` -> RESET. `collision` is ignored.
  - RESET: a down-counter loads `RESET_CYCLES-1` on entry. When the counter reaches 0 -> START. All inputs are ignored.
- Score:
  - On `tick` in START with no `collision`, score increments by 1 in BCD, with per-digit carry.
  - Score saturates at 16'h9999; a tick at 9999 leaves it at 9999 with no milestone.
  - Score is cleared on the RESET -> START and INIT -> START transitions (the cycle START is entered).
  - Score is held in END, so the final score stays visible.
- Tick and collision in the same cycle: collision wins; no increment, no milestone.
- Milestone: asserts for exactly the cycle after an increment that makes the two low digits 00 (e.g. 0099 -> 0100).
- High score: on the START -> END edge, if `score > high_score` as unsigned 16-bit, `high_score <= score`. Packed BCD compares correctly as unsigned.

## Timing
- All outputs are registered.
- Reset values: `game_state`=0, `score`=0, `high_score`=0, `milestone`=0, RESET counter=0.
- Button to state: `btn_start` first high at cycle n -> `game_state` changes at the edge ending cycle n, i.e. visible in cycle n+1.
- Collision to state: `collision` high in cycle n -> END in n+1. `high_score` is updated in that same n+1.
- Tick to score: `game_clk` first high in cycle n -> `score` updated in n+1. `milestone` is high in n+1 only.
- RESET dwell: `game_state`=3 for exactly `RESET_CYCLES` cycles, then 1.
- A level held high produces one event. A held `btn_start` from END gives one RESET, and is not re-seen in START.
- `rst` mid-run overrides everything in that cycle. All registers, including `high_score`, return to reset values the next cycle.

## Configuration
- `GAME_FSM_HISCORE_EN` defined: the `high_score` register and compare logic are built as described.
- Undefined: `high_score` is tied to 16'h0000, with no register and no comparator. Everything else is unchanged.

## Test plan
- Start: `rst` 1 cycle, then `btn_start` high 3 cycles -> `game_state` 0 -> 1 one cycle after the first high cycle. It stays 1, and `score`=0.
- Counting: in START, apply 100 `game_clk` rising edges -> `score`=16'h0100. `milestone` pulses once, the cycle after the 100th edge.
- Collision: at `score`=16'h0042, raise `collision` on the same cycle as a `game_clk` rising edge -> END next cycle, `score` stays 0042, `high_score`=0042.
- Restart: with `RESET_CYCLES`=4, `btn_start` edge in END -> `game_state`=3 for exactly 4 cycles, then 1 with `score`=0. A later run that ends at 0030 leaves `high_score`=0042.
- Saturation: force 9999 increments (or preload via a long run) -> `score`=16'h9999 and stays there on further ticks. `milestone` does not fire.
- Mid-run reset: `rst` during START at `score`=0123 with `high_score`=0042 -> next cycle `game_state`=0, `score`=0, `high_score`=0. With the macro undefined, `high_score` reads 0 throughout.
